// File: rtl/ultrasonic_ranger_pkg.sv
// Shared types and scaling constants for the ultrasonic ranger.
// Converts a microsecond echo width to centimetres with saturation.
package ranger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    CALC,
    FAULT
  } state_t;

  localparam int unsigned SCALE       = 1130;
  localparam int unsigned SCALE_SHIFT = 16;
  localparam int unsigned ECHO_W      = 15;
  localparam int unsigned DIS_W       = 19;

  // cm ~= us / 58, done as a multiply by 1130 and a 16-bit right shift
  function automatic logic [DIS_W-1:0] us_to_cm(input logic [ECHO_W-1:0] us,
                                                input logic [DIS_W-1:0]  max_cm);
    logic [25:0] scaled;
    scaled = (26'(us) * 26'(SCALE)) >> SCALE_SHIFT;
    if (scaled > 26'(max_cm)) begin
      return max_cm;
    end
    return DIS_W'(scaled);
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Sensor-side and result signals of the ranger, bundled for port connection.
interface ultrasonic_ranger_if;
  logic                         echo;
  logic                         trig;
  logic [ranger_pkg::DIS_W-1:0] dis;
  logic                         dis_vld;
  logic                         err;

  modport master (input echo, output trig, output dis, output dis_vld, output err);
  modport slave  (output echo, input trig, input dis, input dis_vld, input err);
endinterface

// File: rtl/ultrasonic_ranger_us_tick_gen.sv
// Free-running divider producing a one-cycle strobe every microsecond.
module us_tick_gen #(
  parameter int unsigned CLK_MHZ = 50
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic tick_1us
);
  localparam int unsigned CNT_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_MHZ - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick_1us = (cnt_reg == CNT_LAST);
endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04-class ranger: periodic trigger, microsecond echo timing, cm conversion
// with timeout and stuck-echo fault reporting.
module ultrasonic_ranger
  import ranger_pkg::*;
#(
  parameter int unsigned CLK_MHZ    = 50,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned PERIOD_MS  = 60,
  parameter int unsigned TIMEOUT_US = 30000,
  parameter int unsigned MAX_CM     = 400
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  ultrasonic_ranger_if.master rng
);
  localparam int unsigned PERIOD_US = PERIOD_MS * 1000;
  localparam int unsigned PER_W     = $clog2(PERIOD_US);
  localparam logic [PER_W-1:0]  PER_LAST     = PER_W'(PERIOD_US - 1);
  localparam logic [ECHO_W-1:0] TRIG_LAST    = ECHO_W'(TRIG_US - 1);
  localparam logic [ECHO_W-1:0] TIMEOUT_LAST = ECHO_W'(TIMEOUT_US - 1);
  localparam logic [ECHO_W-1:0] TIMEOUT_VAL  = ECHO_W'(TIMEOUT_US);
  localparam logic [DIS_W-1:0]  MAX_DIS      = DIS_W'(MAX_CM);

  logic tick_1us;

  us_tick_gen #(.CLK_MHZ(CLK_MHZ)) u_tick (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .tick_1us (tick_1us)
  );

  logic [PER_W-1:0] period_cnt_reg;
  logic             period_wrap;

  assign period_wrap = tick_1us && (period_cnt_reg == PER_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      period_cnt_reg <= '0;
    end else if (period_wrap) begin
      period_cnt_reg <= '0;
    end else if (tick_1us) begin
      period_cnt_reg <= period_cnt_reg + 1'b1;
    end
  end

  // echo is asynchronous: two flops before any decision is taken on it
  logic [1:0] sync_reg;
  logic       echo_d_reg;
  logic       echo_s;
  logic       echo_rise;
  logic       echo_fall;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_reg   <= '0;
      echo_d_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[0], rng.echo};
      echo_d_reg <= sync_reg[1];
    end
  end

  assign echo_s    = sync_reg[1];
  assign echo_rise = echo_s & ~echo_d_reg;
  assign echo_fall = ~echo_s & echo_d_reg;

  state_t            state_reg, state_next;
  logic [ECHO_W-1:0] phase_us_reg, phase_us_next;
  logic [ECHO_W-1:0] echo_us_reg, echo_us_next;
  logic [DIS_W-1:0]  dis_reg, dis_next;
  logic              err_reg, err_next;
  logic              dis_vld_reg, dis_vld_next;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg    <= IDLE;
      phase_us_reg <= '0;
      echo_us_reg  <= '0;
      dis_reg      <= '0;
      err_reg      <= 1'b0;
      dis_vld_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      phase_us_reg <= phase_us_next;
      echo_us_reg  <= echo_us_next;
      dis_reg      <= dis_next;
      err_reg      <= err_next;
      dis_vld_reg  <= dis_vld_next;
    end
  end

  // phase_us times the trigger pulse, then the wait for the echo rise
  always_comb begin
    state_next    = state_reg;
    phase_us_next = phase_us_reg;
    echo_us_next  = echo_us_reg;
    dis_next      = dis_reg;
    err_next      = err_reg;
    dis_vld_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (period_wrap) begin
          phase_us_next = '0;
          echo_us_next  = '0;
          state_next    = echo_s ? FAULT : TRIG;
        end
      end
      TRIG: begin
        if (tick_1us) begin
          if (phase_us_reg == TRIG_LAST) begin
            phase_us_next = '0;
            state_next    = WAIT_RISE;
          end else begin
            phase_us_next = phase_us_reg + 1'b1;
          end
        end
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          state_next = MEASURE;
        end else if (tick_1us) begin
          if (phase_us_reg == TIMEOUT_LAST) begin
            state_next = FAULT;
          end else begin
            phase_us_next = phase_us_reg + 1'b1;
          end
        end
      end
      MEASURE: begin
        if (tick_1us && (echo_us_reg != TIMEOUT_VAL)) begin
          echo_us_next = echo_us_reg + 1'b1;
        end
        if (echo_fall) begin
          state_next = CALC;
        end else if (tick_1us && (echo_us_reg == TIMEOUT_LAST)) begin
          state_next = FAULT;
        end
      end
      CALC: begin
        dis_next     = us_to_cm(echo_us_reg, MAX_DIS);
        err_next     = 1'b0;
        dis_vld_next = 1'b1;
        state_next   = IDLE;
      end
      FAULT: begin
        dis_next     = MAX_DIS;
        err_next     = 1'b1;
        dis_vld_next = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rng.trig    = (state_reg == TRIG);
  assign rng.dis     = dis_reg;
  assign rng.err     = err_reg;
  assign rng.dis_vld = dis_vld_reg;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Scenario bench for ultrasonic_ranger with scaled-down timing parameters and
// a distance model derived directly from the echo width.
module tb_ultrasonic_ranger;
  localparam int CLK_MHZ    = 2;
  localparam int TRIG_US    = 10;
  localparam int PERIOD_MS  = 1;
  localparam int TIMEOUT_US = 700;
  localparam int MAX_CM     = 9;
  localparam int PERIOD_CYC = PERIOD_MS * 1000 * CLK_MHZ;
  localparam int BUDGET     = 3 * PERIOD_CYC;

  logic sys_clk;
  logic sys_rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   vld_total = 0;

  ultrasonic_ranger_if rng_if ();

  ultrasonic_ranger #(
    .CLK_MHZ   (CLK_MHZ),
    .TRIG_US   (TRIG_US),
    .PERIOD_MS (PERIOD_MS),
    .TIMEOUT_US(TIMEOUT_US),
    .MAX_CM    (MAX_CM)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .rng      (rng_if)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    #1;
    if (rng_if.dis_vld === 1'b1) vld_total++;
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation ran past %0d cycles", 95000);
    $fatal(1, "watchdog expired");
  end

  // distance a perfect sensor front end would report for an echo of width_us
  function automatic int model_dis(input int width_us);
    int cm;
    cm = (width_us * 1130) / 65536;
    return (cm > MAX_CM) ? MAX_CM : cm;
  endfunction

  task automatic wait_trig_rise(output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < BUDGET) begin
      @(negedge sys_clk); n++;
      if (rng_if.trig === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_trig_fall(output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < BUDGET) begin
      @(negedge sys_clk); n++;
      if (rng_if.trig === 1'b0) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_vld(output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < BUDGET) begin
      @(negedge sys_clk); n++;
      if (rng_if.dis_vld === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    rng_if.echo = 1'b0;
    sys_rst_n   = 1'b0;
    repeat (5) @(negedge sys_clk);
    checks++; if (rng_if.trig !== 1'b0) begin failures++; $display("FAIL reset_trig: got %b want 0", rng_if.trig); end
    checks++; if (rng_if.dis !== 19'd0) begin failures++; $display("FAIL reset_dis: got %0d want 0", rng_if.dis); end
    checks++; if (rng_if.dis_vld !== 1'b0) begin failures++; $display("FAIL reset_vld: got %b want 0", rng_if.dis_vld); end
    checks++; if (rng_if.err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", rng_if.err); end
    sys_rst_n = 1'b1;
    $display("reset: trig=%b dis=%0d vld=%b err=%b", rng_if.trig, rng_if.dis, rng_if.dis_vld, rng_if.err);
  endtask

  task automatic test_first_trigger();
    int n; bit ok;
    wait_trig_rise(n, ok);
    checks++;
    if (!ok || n < PERIOD_CYC - 1 || n > PERIOD_CYC + 1) begin
      failures++; $display("FAIL first_trig_delay: got %0d cycles want %0d", n, PERIOD_CYC);
      if (!ok) return;
    end
    wait_trig_fall(n, ok);
    checks++;
    if (!ok || n < TRIG_US * CLK_MHZ - 1 || n > TRIG_US * CLK_MHZ + 1) begin
      failures++; $display("FAIL trig_width: got %0d cycles want %0d", n, TRIG_US * CLK_MHZ);
      if (!ok) return;
    end
    wait_vld(n, ok);
    checks++;
    if (!ok || n < TIMEOUT_US * CLK_MHZ || n > TIMEOUT_US * CLK_MHZ + 2) begin
      failures++; $display("FAIL timeout_delay: got %0d cycles want %0d", n, TIMEOUT_US * CLK_MHZ + 1);
      if (!ok) return;
    end
    checks++; if (rng_if.dis !== 19'(MAX_CM)) begin failures++; $display("FAIL timeout_dis: got %0d want %0d", rng_if.dis, MAX_CM); end
    checks++; if (rng_if.err !== 1'b1) begin failures++; $display("FAIL timeout_err: got %b want 1", rng_if.err); end
    $display("no-echo timeout: after %0d cycles dis=%0d err=%b", n, rng_if.dis, rng_if.err);
  endtask

  task automatic test_measure(input int delay_us, input int width_us);
    int n; bit ok; int v0; int exp_cm;
    wait_trig_rise(n, ok);
    checks++; if (!ok) begin failures++; $display("FAIL meas_trig w=%0d: got no trig want trig", width_us); return; end
    wait_trig_fall(n, ok);
    checks++; if (!ok) begin failures++; $display("FAIL meas_trig_fall w=%0d: got trig stuck want low", width_us); return; end
    repeat (delay_us * CLK_MHZ) @(negedge sys_clk);
    rng_if.echo = 1'b1;
    v0 = vld_total;
    repeat (width_us * CLK_MHZ) @(negedge sys_clk);
    rng_if.echo = 1'b0;
    checks++; if (vld_total !== v0) begin failures++; $display("FAIL meas_early w=%0d: got %0d strobes want 0", width_us, vld_total - v0); end
    wait_vld(n, ok);
    checks++; if (!ok || n != 4) begin failures++; $display("FAIL meas_latency w=%0d: got %0d cycles want 4", width_us, n); if (!ok) return; end
    exp_cm = model_dis(width_us);
    checks++; if (rng_if.dis !== 19'(exp_cm)) begin failures++; $display("FAIL meas_dis w=%0d: got %0d want %0d", width_us, rng_if.dis, exp_cm); end
    checks++; if (rng_if.err !== 1'b0) begin failures++; $display("FAIL meas_err w=%0d: got %b want 0", width_us, rng_if.err); end
    @(negedge sys_clk);
    checks++; if (rng_if.dis_vld !== 1'b0) begin failures++; $display("FAIL meas_vld_width w=%0d: got %b want 0", width_us, rng_if.dis_vld); end
    $display("measure: delay=%0dus width=%0dus dis=%0d (model %0d) err=%b latency=%0d", delay_us, width_us, rng_if.dis, exp_cm, rng_if.err, n);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      test_measure(int'($urandom_range(1, 200)), int'($urandom_range(1, TIMEOUT_US - 1)));
    end
  endtask

  task automatic test_long_echo();
    int n; bit ok; int v0; int v1;
    wait_trig_rise(n, ok);
    checks++; if (!ok) begin failures++; $display("FAIL long_trig: got no trig want trig"); return; end
    wait_trig_fall(n, ok);
    repeat (30 * CLK_MHZ) @(negedge sys_clk);
    rng_if.echo = 1'b1;
    v0 = vld_total;
    wait_vld(n, ok);
    checks++;
    if (!ok || n < TIMEOUT_US * CLK_MHZ + 2 || n > TIMEOUT_US * CLK_MHZ + CLK_MHZ + 5) begin
      failures++; $display("FAIL long_fault_time: got %0d cycles want ~%0d", n, TIMEOUT_US * CLK_MHZ + 4);
      if (!ok) begin rng_if.echo = 1'b0; return; end
    end
    checks++; if (rng_if.dis !== 19'(MAX_CM)) begin failures++; $display("FAIL long_dis: got %0d want %0d", rng_if.dis, MAX_CM); end
    checks++; if (rng_if.err !== 1'b1) begin failures++; $display("FAIL long_err: got %b want 1", rng_if.err); end
    v1 = vld_total;
    checks++; if (v1 !== v0 + 1) begin failures++; $display("FAIL long_strobes: got %0d want 1", v1 - v0); end
    repeat (800 * CLK_MHZ - n) @(negedge sys_clk);
    rng_if.echo = 1'b0;
    repeat (100 * CLK_MHZ) @(negedge sys_clk);
    checks++; if (vld_total !== v1) begin failures++; $display("FAIL long_late_fall: got %0d strobes want 0", vld_total - v1); end
    $display("long echo: fault after %0d cycles dis=%0d err=%b", n, rng_if.dis, rng_if.err);
  endtask

  task automatic test_stuck();
    int n; bit ok; bit trig_seen;
    rng_if.echo = 1'b1;
    trig_seen = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge sys_clk);
      if (rng_if.trig === 1'b1) trig_seen = 1'b1;
      if (rng_if.dis_vld === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL stuck_strobe: got none want 1"); rng_if.echo = 1'b0; return; end
    checks++; if (trig_seen !== 1'b0) begin failures++; $display("FAIL stuck_trig: got trig=1 want 0"); end
    checks++; if (rng_if.dis !== 19'(MAX_CM)) begin failures++; $display("FAIL stuck_dis: got %0d want %0d", rng_if.dis, MAX_CM); end
    checks++; if (rng_if.err !== 1'b1) begin failures++; $display("FAIL stuck_err: got %b want 1", rng_if.err); end
    rng_if.echo = 1'b0;
    wait_trig_rise(n, ok);
    checks++; if (!ok || n < PERIOD_CYC - 2 || n > PERIOD_CYC) begin failures++; $display("FAIL stuck_next_trig: got %0d cycles want %0d", n, PERIOD_CYC - 1); end
    $display("stuck echo: dis=%0d err=%b next trig after %0d cycles", rng_if.dis, rng_if.err, n);
    test_measure(100, 290);
  endtask

  task automatic test_reset_mid();
    int n; bit ok; int v0;
    wait_trig_rise(n, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_mid_trig: got no trig want trig"); return; end
    wait_trig_fall(n, ok);
    repeat (100 * CLK_MHZ) @(negedge sys_clk);
    rng_if.echo = 1'b1;
    repeat (200 * CLK_MHZ) @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++; if (rng_if.trig !== 1'b0) begin failures++; $display("FAIL rst_mid_trig_out: got %b want 0", rng_if.trig); end
    checks++; if (rng_if.dis !== 19'd0) begin failures++; $display("FAIL rst_mid_dis: got %0d want 0", rng_if.dis); end
    checks++; if (rng_if.err !== 1'b0) begin failures++; $display("FAIL rst_mid_err: got %b want 0", rng_if.err); end
    checks++; if (rng_if.dis_vld !== 1'b0) begin failures++; $display("FAIL rst_mid_vld: got %b want 0", rng_if.dis_vld); end
    v0 = vld_total;
    rng_if.echo = 1'b0;
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_trig_rise(n, ok);
    checks++; if (!ok || n < PERIOD_CYC - 1 || n > PERIOD_CYC + 1) begin failures++; $display("FAIL rst_mid_restart: got %0d cycles want %0d", n, PERIOD_CYC); end
    checks++; if (vld_total !== v0) begin failures++; $display("FAIL rst_mid_strobe: got %0d strobes want 0", vld_total - v0); end
    checks++; if (rng_if.dis !== 19'd0) begin failures++; $display("FAIL rst_mid_dis_hold: got %0d want 0", rng_if.dis); end
    $display("reset mid-measure: restart trig after %0d cycles dis=%0d", n, rng_if.dis);
    test_measure(50, 290);
  endtask

  initial begin
    test_reset();
    test_first_trigger();
    test_measure(200, 290);
    test_measure(200, 580);
    test_measure(50, 1);
    test_measure(50, 521);
    test_measure(50, 522);
    test_measure(20, TIMEOUT_US - 1);
    test_random();
    test_long_echo();
    test_stuck();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
